// File: rtl/kernel_spi_pkg.sv
// Shared definitions for the kernel SPI master and slave peripherals:
// register addresses, status/control bit positions and FSM states.
package kernel_spi_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOP     = 3'd6;

    // Status flags and their interrupt enables share bit positions.
    localparam int BIT_ROE  = 3;
    localparam int BIT_TOE  = 4;
    localparam int BIT_TMT  = 5;
    localparam int BIT_TRDY = 6;
    localparam int BIT_RRDY = 7;
    localparam int BIT_E    = 8;
    localparam int BIT_EOP  = 9;
    localparam int BIT_SSO  = 10;

    localparam logic [10:0] CTL_MASK = 11'h7D8;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_state_t;

endpackage

// File: rtl/kernel_spi_clkgen.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled and
// pulses tick on the terminal count; held at zero when disabled.
module kernel_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (!enable || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/kernel_spi_master.sv
// Mode 0, MSB-first, 8-bit SPI master with double-buffered tx/rx and a
// CPU register model matching the kernel SPI slave peripheral.
module kernel_spi_master
    import kernel_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SS_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_from_cpu,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    input  logic        MISO,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    output logic        SCLK,
    output logic        SS_n,
    output logic        MOSI
);

    // Lead/trail gaps are measured in whole SCLK periods (two ticks each).
    localparam int DLY_TICKS = 2 * SS_DELAY;
    localparam int DW = (DLY_TICKS > 1) ? $clog2(DLY_TICKS) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(DLY_TICKS - 1);

    spi_state_t state, state_next;

    logic          tick;
    logic [7:0]    shift_reg, tx_hold, rx_hold, rx_byte;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] dly_cnt;
    logic          sample;
    logic          trdy, rrdy, toe, roe, eop;
    logic [10:0]   ctl;
    logic [15:0]   eop_value, status_word;
    logic          wr_en, rd_en, wr_tx, wr_status, rd_rx, eop_hit, overrun;
    logic          load_tx, byte_done, sclk_rise, sclk_fall, dly_done, ss_low, ss_high;

    kernel_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .tick    (tick)
    );

    assign wr_en     = spi_select & ~write_n;
    assign rd_en     = spi_select & ~read_n;
    assign wr_tx     = wr_en && (mem_addr == ADDR_TXDATA);
    assign wr_status = wr_en && (mem_addr == ADDR_STATUS);
    assign rd_rx     = rd_en && (mem_addr == ADDR_RXDATA);
    assign rx_byte   = {shift_reg[6:0], sample};
    assign overrun   = rrdy && !rd_rx;
    assign dly_done  = tick && (dly_cnt == DLY_LAST);
    assign eop_hit   = (wr_tx && ({8'h00, data_from_cpu[7:0]} == eop_value)) ||
                       (rd_rx && ({8'h00, rx_hold} == eop_value));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        byte_done  = 1'b0;
        sclk_rise  = 1'b0;
        sclk_fall  = 1'b0;
        ss_low     = 1'b0;
        ss_high    = 1'b0;
        case (state)
            IDLE: begin
                if (!trdy) begin
                    load_tx = 1'b1;
                    if (!SS_n && ctl[BIT_SSO]) begin
                        state_next = SHIFT;
                    end else begin
                        ss_low     = 1'b1;
                        state_next = LEAD;
                    end
                end else if (!ctl[BIT_SSO]) begin
                    ss_high = 1'b1;
                end
            end
            LEAD: begin
                if (dly_done)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (!SCLK) begin
                        sclk_rise = 1'b1;
                    end else begin
                        sclk_fall = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            byte_done = 1'b1;
                            if (!trdy && ctl[BIT_SSO])
                                load_tx = 1'b1;
                            else
                                state_next = TRAIL;
                        end
                    end
                end
            end
            TRAIL: begin
                if (dly_done) begin
                    state_next = IDLE;
                    ss_high    = !ctl[BIT_SSO];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath: shifter, SCLK/SS_n generation and receive holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sample    <= 1'b0;
            SCLK      <= 1'b0;
            SS_n      <= 1'b1;
            dly_cnt   <= '0;
            rx_hold   <= '0;
        end else begin
            if (load_tx) begin
                shift_reg <= tx_hold;
                bit_cnt   <= '0;
            end else if (sclk_fall) begin
                shift_reg <= rx_byte;
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (sclk_rise) begin
                SCLK   <= 1'b1;
                sample <= MISO;
            end else if (sclk_fall) begin
                SCLK <= 1'b0;
            end
            if (ss_low)
                SS_n <= 1'b0;
            else if (ss_high)
                SS_n <= 1'b1;
            if (state == LEAD || state == TRAIL) begin
                if (tick)
                    dly_cnt <= dly_done ? '0 : dly_cnt + 1'b1;
            end else begin
                dly_cnt <= '0;
            end
            if (byte_done && !overrun)
                rx_hold <= rx_byte;
        end
    end

    // CPU-visible flags; hardware set events take priority over clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trdy      <= 1'b1;
            rrdy      <= 1'b0;
            toe       <= 1'b0;
            roe       <= 1'b0;
            eop       <= 1'b0;
            tx_hold   <= '0;
            ctl       <= '0;
            eop_value <= '0;
        end else begin
            if (load_tx)
                trdy <= 1'b1;
            else if (wr_tx)
                trdy <= 1'b0;
            if (wr_tx && trdy)
                tx_hold <= data_from_cpu[7:0];
            if (wr_tx && !trdy)
                toe <= 1'b1;
            else if (wr_status)
                toe <= 1'b0;
            if (byte_done)
                rrdy <= 1'b1;
            else if (rd_rx || wr_status)
                rrdy <= 1'b0;
            if (byte_done && overrun)
                roe <= 1'b1;
            else if (wr_status)
                roe <= 1'b0;
            if (eop_hit)
                eop <= 1'b1;
            else if (wr_status)
                eop <= 1'b0;
            if (wr_en && mem_addr == ADDR_CONTROL)
                ctl <= data_from_cpu[10:0] & CTL_MASK;
            if (wr_en && mem_addr == ADDR_EOP)
                eop_value <= data_from_cpu;
        end
    end

    always_comb begin
        status_word           = '0;
        status_word[BIT_EOP]  = eop;
        status_word[BIT_E]    = toe | roe;
        status_word[BIT_RRDY] = rrdy;
        status_word[BIT_TRDY] = trdy;
        status_word[BIT_TMT]  = trdy && (state == IDLE);
        status_word[BIT_TOE]  = toe;
        status_word[BIT_ROE]  = roe;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (rd_en) begin
                case (mem_addr)
                    ADDR_RXDATA:  data_to_cpu <= {8'h00, rx_hold};
                    ADDR_STATUS:  data_to_cpu <= status_word;
                    ADDR_CONTROL: data_to_cpu <= {5'd0, ctl};
                    ADDR_EOP:     data_to_cpu <= eop_value;
                    default:      data_to_cpu <= '0;
                endcase
            end
            irq <= (eop & ctl[BIT_EOP]) | ((toe | roe) & ctl[BIT_E]) |
                   (rrdy & ctl[BIT_RRDY]) | (trdy & ctl[BIT_TRDY]) |
                   (toe & ctl[BIT_TOE]) | (roe & ctl[BIT_ROE]);
        end
    end

    assign dataavailable = rrdy;
    assign readyfordata  = trdy;
    assign endofpacket   = eop;
    assign MOSI          = shift_reg[7];

endmodule

// File: tb/tb_kernel_spi_master.sv
// Directed bench for kernel_spi_master with a loopback mode-0 slave model.
module tb_kernel_spi_master;
    import kernel_spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_from_cpu = '0;
    logic [2:0]  mem_addr = '0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic        spi_select = 1'b0;
    logic        MISO;
    logic [15:0] data_to_cpu;
    logic        irq, dataavailable, readyfordata, endofpacket, SCLK, SS_n, MOSI;

    int vectors = 0;
    int miscompares = 0;

    kernel_spi_master #(.CLK_DIV(4), .SS_DELAY(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_from_cpu (data_from_cpu),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .spi_select    (spi_select),
        .MISO          (MISO),
        .data_to_cpu   (data_to_cpu),
        .irq           (irq),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata),
        .endofpacket   (endofpacket),
        .SCLK          (SCLK),
        .SS_n          (SS_n),
        .MOSI          (MOSI)
    );

    always #5 clk = ~clk;

    // Slave model: captures MOSI on rising SCLK, presents slave_data MSB-first.
    int          tb_cycle = 0;
    int          rise_cyc [64];
    logic [7:0]  rise_count = '0;
    logic [7:0]  fall_count = '0;
    logic [15:0] mosi_cap = '0;
    logic [15:0] slave_data = '0;
    logic [3:0]  slave_base = '0;

    always @(posedge clk) tb_cycle <= tb_cycle + 1;

    always @(posedge SCLK) begin
        mosi_cap <= {mosi_cap[14:0], MOSI};
        rise_cyc[rise_count[5:0]] <= tb_cycle;
        rise_count <= rise_count + 8'd1;
    end

    always @(negedge SCLK) fall_count <= fall_count + 8'd1;

    assign MISO = slave_data[4'd15 - (fall_count[3:0] - slave_base)];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic is_write, input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        spi_select    = 1'b1;
        mem_addr      = addr;
        data_from_cpu = data;
        write_n       = ~is_write;
        read_n        = is_write;
        @(posedge clk);
        #1;
        spi_select = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
    endtask

    task automatic waitIdle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
            done = data_to_cpu[BIT_TMT];
        end
        checkOutput(tag, {15'd0, done}, 16'd1);
    endtask

    task automatic armSlave(input logic [7:0] first, input logic [7:0] second, output logic [7:0] base_rise);
        slave_data = {first, second};
        slave_base = fall_count[3:0];
        base_rise  = rise_count;
    endtask

    initial begin
        int         cycles;
        logic       done, seen_low, ss_high_seen;
        logic [7:0] base_rise;
        logic [5:0] ri;

        // Reset state
        #23;
        checkOutput("rst_ss_n", {15'd0, SS_n}, 16'd1);
        checkOutput("rst_sclk", {15'd0, SCLK}, 16'd0);
        checkOutput("rst_mosi", {15'd0, MOSI}, 16'd0);
        checkOutput("rst_data", data_to_cpu, 16'h0000);
        checkOutput("rst_irq", {15'd0, irq}, 16'd0);
        checkOutput("rst_trdy", {15'd0, readyfordata}, 16'd1);
        checkOutput("rst_rrdy", {15'd0, dataavailable}, 16'd0);
        checkOutput("rst_eop", {15'd0, endofpacket}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("rst_status", data_to_cpu, 16'h0060);
        applyStimulus(1'b0, ADDR_CONTROL, 16'h0000);
        checkOutput("rst_control", data_to_cpu, 16'h0000);

        // Single byte 0xA5 out, 0x3C back; byte time from write to SS_n release
        armSlave(8'h3C, 8'h00, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h00A5);
        cycles = 0; seen_low = 1'b0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!SS_n) seen_low = 1'b1;
            else if (seen_low) done = 1'b1;
        end
        checkOutput("t1_ss_release", {15'd0, done}, 16'd1);
        checkOutput("t2_byte_time", 16'(cycles), 16'd81);
        checkOutput("t1_sclk_rises", 16'(rise_count - base_rise), 16'd8);
        checkOutput("t1_mosi_bits", {8'd0, mosi_cap[7:0]}, 16'h00A5);
        checkOutput("t1_rrdy_pin", {15'd0, dataavailable}, 16'd1);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t1_status", data_to_cpu, 16'h00E0);
        applyStimulus(1'b0, ADDR_RXDATA, 16'h0000);
        checkOutput("t1_rxdata", data_to_cpu, 16'h003C);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t1_status_after_read", data_to_cpu, 16'h0060);

        // Back-to-back writes: second one overruns, irq follows TOE by a cycle
        applyStimulus(1'b1, ADDR_CONTROL, 16'h0010);
        armSlave(8'h81, 8'h00, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h005A);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h0066);
        checkOutput("t3_irq_same_cycle", {15'd0, irq}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("t3_irq_after_toe", {15'd0, irq}, 16'd1);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t3_status_busy", data_to_cpu, 16'h0150);
        waitIdle("t3_idle");
        checkOutput("t3_sclk_rises", 16'(rise_count - base_rise), 16'd8);
        checkOutput("t3_mosi_first_only", {8'd0, mosi_cap[7:0]}, 16'h005A);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t3_status_done", data_to_cpu, 16'h01F0);
        applyStimulus(1'b0, ADDR_RXDATA, 16'h0000);
        checkOutput("t3_rxdata", data_to_cpu, 16'h0081);
        applyStimulus(1'b1, ADDR_STATUS, 16'hFFFF);
        applyStimulus(1'b1, ADDR_CONTROL, 16'h0000);
        checkOutput("t3_irq_cleared", {15'd0, irq}, 16'd0);

        // SSO chaining: 0x11 then 0x22 with no gap; second rx byte overruns
        applyStimulus(1'b1, ADDR_CONTROL, 16'h0400);
        armSlave(8'hC3, 8'h5E, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h0011);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            done = readyfordata;
        end
        checkOutput("t4_first_consumed", {15'd0, done}, 16'd1);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h0022);
        ss_high_seen = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(posedge clk);
            #1;
            if (SS_n) ss_high_seen = 1'b1;
        end
        checkOutput("t4_ss_held_low", {15'd0, ss_high_seen}, 16'd0);
        checkOutput("t4_sclk_rises", 16'(rise_count - base_rise), 16'd16);
        checkOutput("t4_mosi_bits", mosi_cap, 16'h1122);
        ri = base_rise[5:0] + 6'd7;
        checkOutput("t4_no_gap", 16'(rise_cyc[ri + 6'd1] - rise_cyc[ri]), 16'd8);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t4_status_roe", data_to_cpu, 16'h01E8);
        applyStimulus(1'b0, ADDR_RXDATA, 16'h0000);
        checkOutput("t4_rxdata_kept", data_to_cpu, 16'h00C3);
        applyStimulus(1'b1, ADDR_CONTROL, 16'h0000);
        checkOutput("t4_ss_until_clear", {15'd0, SS_n}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("t4_ss_released", {15'd0, SS_n}, 16'd1);
        applyStimulus(1'b1, ADDR_STATUS, 16'h0000);

        // End-of-packet match on transmit, cleared by a status write
        applyStimulus(1'b1, ADDR_EOP, 16'h0022);
        armSlave(8'h9A, 8'h00, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h0022);
        checkOutput("t5_eop_pin", {15'd0, endofpacket}, 16'd1);
        waitIdle("t5_idle");
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t5_status_eop", data_to_cpu, 16'h02E0);
        applyStimulus(1'b0, ADDR_EOP, 16'h0000);
        checkOutput("t5_eop_value", data_to_cpu, 16'h0022);
        applyStimulus(1'b1, ADDR_STATUS, 16'h1234);
        applyStimulus(1'b0, ADDR_STATUS, 16'h0000);
        checkOutput("t5_status_cleared", data_to_cpu, 16'h0060);
        checkOutput("t5_eop_pin_cleared", {15'd0, endofpacket}, 16'd0);

        // Asynchronous reset in the middle of a byte, then a clean transfer
        armSlave(8'h0F, 8'h00, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h00F0);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (8'(rise_count - base_rise) >= 8'd4);
        end
        checkOutput("t6_reached_bit4", {15'd0, done}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_ss_n_async", {15'd0, SS_n}, 16'd1);
        checkOutput("t6_sclk_async", {15'd0, SCLK}, 16'd0);
        checkOutput("t6_trdy_async", {15'd0, readyfordata}, 16'd1);
        checkOutput("t6_rrdy_async", {15'd0, dataavailable}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        armSlave(8'hD4, 8'h00, base_rise);
        applyStimulus(1'b1, ADDR_TXDATA, 16'h006B);
        waitIdle("t6_idle");
        checkOutput("t6_sclk_rises", 16'(rise_count - base_rise), 16'd8);
        checkOutput("t6_mosi_bits", {8'd0, mosi_cap[7:0]}, 16'h006B);
        applyStimulus(1'b0, ADDR_RXDATA, 16'h0000);
        checkOutput("t6_rxdata", data_to_cpu, 16'h00D4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
